instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Instruction fetch queue between the program counter / instruction memory read and the decode stage.
- Captures {pc, instruction} pairs produced each cycle by fetch and buffers them in a small circular FIFO.
- Presents them to decode with a valid/ready handshake.
- Back-pressures the PC via fetch_ready, and discards everything on a branch/jump flush.

Parameters:
- ADDR_W, 8, PC / byte-address width; matches the 8-bit PC.
- INSTR_W, 32, instruction word width.
- DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_valid  input  1  fetch side offers an entry this cycle.
- fetch_pc  input  ADDR_W  address of offered instruction (signed; MSB set = negative).
- fetch_instr  input  INSTR_W  instruction word read at fetch_pc.
- fetch_ready  output  1  queue can accept; the PC advances only when high.
- flush  input  1  discard all queued entries (redirect).
- id_valid  output  1  head entry available to decode.
- id_ready  input  1  decode consumes head this cycle.
- id_pc  output  ADDR_W  head entry PC; 0 when id_valid=0.
- id_instr  output  INSTR_W  head entry instruction; 0 when id_valid=0.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset: count=0, read/write pointers=0, id_valid=0, id_pc=0, id_instr=0, fetch_ready=1 from the first cycle after the reset edge.
- Storage: DEPTH-entry register array of {pc, instr}; write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- fetch_ready: combinational, = (count != DEPTH). It does not depend on id_ready; there is no full-queue pass-through.
- Enqueue condition: fetch_valid && fetch_ready && !flush && (fetch_pc[ADDR_W-1]==0).
  - On enqueue: write the entry at wptr, then wptr+1.
- Negative-PC filter: an offer with fetch_pc MSB=1 (e.g. the 0xFC start-up value) is accepted, because fetch_ready is unaffected, but is dropped silently. It is never enqueued.
- Dequeue condition: id_valid && id_ready && !flush.
  - On dequeue: rptr+1.
- id_valid: = (count != 0). id_pc/id_instr are driven combinationally from array[rptr] when valid, else 0.
- Latency: an entry enqueued at edge N is visible on id_* after edge N (one cycle), when the queue was empty.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Allowed at any occupancy where both conditions hold (1..DEPTH-1).
- Full: no enqueue possible. A dequeue in the same cycle raises fetch_ready only from the next cycle.
- Empty: id_valid=0, so no dequeue. id_ready is ignored.
- flush: highest priority after reset. count=0 and pointers=0 at the next edge.
  - Any same-cycle enqueue or dequeue is discarded.
  - Array contents need not be cleared.
- reset mid-operation: identical to flush plus output zeroing. Reset overrides flush.
- count never exceeds DEPTH and never underflows. The bench asserts 0 <= count <= DEPTH every cycle.

Optional Feature:
- Macro: IFQ_TRACE_EN.
- Defined: simulation-only $display on every enqueue ("IFQ enq pc=%d"), dequeue ("IFQ deq pc=%d"), flush, and dropped negative-PC offer. Guarded by the macro and excluded from synthesis.
- Undefined: no display statements are compiled. Cycle behaviour is identical.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - ADDR_W and INSTR_W constants.
  - Typedef fetch_entry_t {pc, instr}.
  - NOP_INSTR constant (32'h00000013), reserved for future bubble insertion.
- One natural sub-module: ifq_ptr_ctrl, which holds the pointers, count, full/empty and the enqueue/dequeue qualification.
- The top instantiates ifq_ptr_ctrl plus the storage array and the output mux.

Test Plan:
- Reset then offer pc=0xFC valid -> fetch_ready=1, entry dropped, count stays 0, id_valid=0.
- Offer pc=0,4,8,12 on consecutive cycles with id_ready=0 -> count=4, fetch_ready=0. A 5th offer pc=16 is not accepted. id_pc=0.
- From full, id_ready=1 for 4 cycles with fetch_valid=0 -> id_pc sequence 0,4,8,12 with matching instrs, then id_valid=0 and count=0.
- Streaming: fetch_valid=1 and id_ready=1 every cycle, pc=0,4,8,... -> count settles at 1 after the first edge, id_pc lags fetch_pc by one cycle, and pointers wrap past DEPTH without loss.
- count=3 with flush=1 alongside fetch_valid (pc=20) and id_ready=1 -> next cycle count=0, id_valid=0, pc=20 not present. Next enqueue of pc=40 appears at head.
- reset asserted while count=2 and an enqueue is pending -> next cycle count=0, id_pc=0, id_instr=0, fetch_ready=1.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-side types and constants.
// Entry layout used by the instruction fetch queue.
package rv_fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;

  // Reserved for future bubble insertion.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the fetch queue.
// master drives fetch/decode requests; slave is the queue.
interface instr_fetch_queue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic               fetch_valid;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_ready;
  logic               flush;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic [CW-1:0]      count;

  modport master (
    output fetch_valid, fetch_pc, fetch_instr,
    output flush, id_ready,
    input  fetch_ready, id_valid,
    input  id_pc, id_instr, count
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr,
    input  flush, id_ready,
    output fetch_ready, id_valid,
    output id_pc, id_instr, count
  );

endinterface

// File: rtl/instr_fetch_queue_ptr_ctrl.sv
// Pointer / occupancy control for the fetch queue.
// Qualifies enqueue and dequeue; flush clears everything.
module ifq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_valid_i,
  input  logic          neg_pc_i,
  input  logic          flush_i,
  input  logic          id_ready_i,
  output logic          enq_o,
  output logic          deq_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] wptr_o,
  output logic [AW-1:0] rptr_o,
  output logic [CW-1:0] count_o
);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Negative-PC offers are handshaken but never stored.
  assign enq_o = fetch_valid_i && !full_o
              && !flush_i && !neg_pc_i;
  assign deq_o = !empty_o && id_ready_i
              && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq_o) wptr_d = wptr_q + 1'b1;
      if (deq_o) rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(enq_o)
              - CW'(deq_o);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular FIFO of {pc, instr} between fetch and decode.
// Define IFQ_TRACE_EN for simulation-only event tracing.
module instr_fetch_queue #(
  parameter int ADDR_W  = rv_fetch_pkg::ADDR_W,
  parameter int INSTR_W = rv_fetch_pkg::INSTR_W,
  parameter int DEPTH   = 4
) (
  input logic clk,
  input logic reset,
  instr_fetch_queue_if.slave bus
);

  import rv_fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          enq, deq, full, empty;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t wr_ent, head;

  ifq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_ptr (
    .clk           (clk),
    .reset         (reset),
    .fetch_valid_i (bus.fetch_valid),
    .neg_pc_i      (bus.fetch_pc[ADDR_W-1]),
    .flush_i       (bus.flush),
    .id_ready_i    (bus.id_ready),
    .enq_o         (enq),
    .deq_o         (deq),
    .full_o        (full),
    .empty_o       (empty),
    .wptr_o        (wptr),
    .rptr_o        (rptr),
    .count_o       (count)
  );

  assign wr_ent.pc    = bus.fetch_pc;
  assign wr_ent.instr = bus.fetch_instr;

  always_ff @(posedge clk) begin
    if (enq) mem_q[wptr] <= wr_ent;
  end

  assign head = mem_q[rptr];

  assign bus.fetch_ready = !full;
  assign bus.id_valid    = !empty;
  assign bus.count       = count;
  assign bus.id_pc       = empty ? '0 : head.pc;
  assign bus.id_instr    = empty ? '0 : head.instr;

`ifdef IFQ_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus.flush) begin
        $display("IFQ flush");
      end else begin
        if (enq)
          $display("IFQ enq pc=%d",
                   $signed(bus.fetch_pc));
        if (deq)
          $display("IFQ deq pc=%d",
                   $signed(head.pc));
        if (bus.fetch_valid && !full
            && bus.fetch_pc[ADDR_W-1])
          $display("IFQ drop pc=%d",
                   $signed(bus.fetch_pc));
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue.
// Directed plan steps followed by random traffic.
module tb_instr_fetch_queue;

  localparam int AW    = 8;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  instr_fetch_queue_if #(
    .ADDR_W (AW),
    .INSTR_W(IW),
    .DEPTH  (DEPTH)
  ) bus ();

  instr_fetch_queue #(
    .ADDR_W (AW),
    .INSTR_W(IW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] ins;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins_of(
    logic [AW-1:0] pc);
    return 32'hA5000000 | {24'h0, pc} << 4;
  endfunction

  task automatic drv(logic v, logic [AW-1:0] pc,
                     logic [IW-1:0] ins,
                     logic rdy, logic fl);
    bus.fetch_valid = v;
    bus.fetch_pc    = pc;
    bus.fetch_instr = ins;
    bus.id_ready    = rdy;
    bus.flush       = fl;
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("count", 32'(bus.count), 32'(sz));
    chk("fetch_ready", 32'(bus.fetch_ready),
        32'(sz != DEPTH));
    chk("id_valid", 32'(bus.id_valid),
        32'(sz != 0));
    chk("id_pc", 32'(bus.id_pc),
        sz ? 32'(mq[0].pc) : 32'd0);
    chk("id_instr", bus.id_instr,
        sz ? mq[0].ins : 32'd0);
    chk("count_le_depth",
        32'(bus.count <= DEPTH), 32'd1);
  endtask

  task automatic model_edge();
    bit acc, d;
    if (reset || bus.flush) begin
      mq.delete();
    end else begin
      acc = bus.fetch_valid
         && (mq.size() < DEPTH)
         && !bus.fetch_pc[AW-1];
      d = (mq.size() > 0) && bus.id_ready;
      if (d) void'(mq.pop_front());
      if (acc) mq.push_back('{bus.fetch_pc,
                              bus.fetch_instr});
    end
  endtask

  task automatic step();
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic offer(logic [AW-1:0] pc,
                       logic rdy);
    drv(1'b1, pc, ins_of(pc), rdy, 1'b0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_valid", 32'(bus.id_valid), 0);
    chk("rst_ready", 32'(bus.fetch_ready), 1);
    chk("rst_pc", 32'(bus.id_pc), 0);
    chk("rst_instr", bus.id_instr, 0);

    offer(8'hFC, 1'b0);
    chk("neg_count", 32'(bus.count), 0);
    chk("neg_valid", 32'(bus.id_valid), 0);
    chk("neg_ready", 32'(bus.fetch_ready), 1);

    for (int i = 0; i < 4; i++)
      offer(8'(i * 4), 1'b0);
    chk("full_count", 32'(bus.count), 4);
    chk("full_ready", 32'(bus.fetch_ready), 0);
    offer(8'd16, 1'b0);
    chk("full_hold", 32'(bus.count), 4);
    chk("full_head", 32'(bus.id_pc), 0);

    drv(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 32'(bus.id_pc), i * 4);
      chk("drain_ins", bus.id_instr,
          ins_of(8'(i * 4)));
      step();
    end
    chk("drain_valid", 32'(bus.id_valid), 0);
    chk("drain_count", 32'(bus.count), 0);

    for (int i = 0; i < 10; i++) begin
      offer(8'(i * 4), 1'b1);
      chk("strm_count", 32'(bus.count), 1);
      chk("strm_pc", 32'(bus.id_pc), i * 4);
    end
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    step();

    for (int i = 0; i < 3; i++)
      offer(8'(100 + i * 4), 1'b0);
    chk("pre_flush", 32'(bus.count), 3);
    drv(1'b1, 8'd20, ins_of(8'd20),
        1'b1, 1'b1);
    step();
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_valid", 32'(bus.id_valid), 0);
    offer(8'd40, 1'b0);
    chk("post_flush", 32'(bus.id_pc), 40);
    drv(1'b0, '0, '0, 1'b1, 1'b0);
    step();

    offer(8'd60, 1'b0);
    offer(8'd64, 1'b0);
    chk("pre_rst", 32'(bus.count), 2);
    drv(1'b1, 8'd68, ins_of(8'd68),
        1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
    drv(1'b0, '0, '0, 1'b0, 1'b0);
    chk("mrst_count", 32'(bus.count), 0);
    chk("mrst_pc", 32'(bus.id_pc), 0);
    chk("mrst_ins", bus.id_instr, 0);
    chk("mrst_ready", 32'(bus.fetch_ready), 1);

    for (int i = 0; i < 400; i++) begin
      drv(1'($urandom_range(0, 3) != 0),
          8'($urandom),
          $urandom,
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 19) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
